// File: rtl/sha256_pkg.sv
// ============================================================================
// sha256_pkg : shared types and geometry for the SHA-256 block sequencer
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int WordSize   = 32;
    localparam int BlockWidth = 512;
    localparam int NumWords   = BlockWidth / WordSize;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HASH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/sha256_word_buf.sv
// ============================================================================
// sha256_word_buf : assembles stream words into one big-endian core block
// Revision        : 1.0
// ============================================================================
`default_nettype none

module sha256_word_buf
    import sha256_pkg::*;
#(
    parameter int WordSize   = sha256_pkg::WordSize,
    parameter int BlockWidth = sha256_pkg::BlockWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  wr_i,
    input  logic [WordSize-1:0]   data_i,
    output logic                  last_word_o,
    output logic [BlockWidth-1:0] block_o
);

    localparam int NUM_WORDS = BlockWidth / WordSize;
    localparam int CNT_W     = $clog2(NUM_WORDS);

    logic [CNT_W-1:0]      word_cnt_q;
    logic [BlockWidth-1:0] block_q;

    assign last_word_o = (word_cnt_q == CNT_W'(NUM_WORDS - 1));
    assign block_o     = block_q;

    // Word 0 lands in the most significant slot of the block.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_cnt_q <= '0;
            block_q    <= '0;
        end else if (clr_i) begin
            word_cnt_q <= '0;
        end else if (wr_i) begin
            block_q[BlockWidth - 1 - WordSize * int'(word_cnt_q) -: WordSize] <= data_i;
            word_cnt_q <= last_word_o ? '0 : word_cnt_q + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sha256_block_seq.sv
// ============================================================================
// sha256_block_seq : feeds stream words to a SHA-256 core block by block and
//                    captures the final digest, with abort and watchdog
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sha256_block_seq
    import sha256_pkg::*;
#(
    parameter int WordSize      = sha256_pkg::WordSize,
    parameter int BlockWidth    = sha256_pkg::BlockWidth,
    parameter int TimeoutCycles = 96
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [WordSize-1:0]   s_data_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic                  s_last_i,
    output logic [BlockWidth-1:0] block_o,
    output logic                  enable_hash_o,
    output logic                  rst_hash_o,
    input  logic                  hold_i,
    input  logic                  idle_i,
    input  logic                  digest_valid_i,
    input  logic [255:0]          digest_i,
    output logic [255:0]          digest_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [15:0]           block_cnt_o
);

    localparam int WD_W = $clog2(TimeoutCycles + 1);

    state_e         state_q, state_d;
    logic [15:0]    block_cnt_q, block_cnt_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic           last_seen_q, last_seen_d;
    logic           error_q, error_d;
    logic [255:0]   digest_q, digest_d;

    logic w_buf_clr, w_buf_wr, w_last_word, w_rst_hash;
    logic w_unused;

    // Core status idle_i and the final-block flag are informational only.
    assign w_unused = ^{idle_i, last_seen_q};

    sha256_word_buf #(
        .WordSize   (WordSize),
        .BlockWidth (BlockWidth)
    ) u_word_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (w_buf_clr),
        .wr_i        (w_buf_wr),
        .data_i      (s_data_i),
        .last_word_o (w_last_word),
        .block_o     (block_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            block_cnt_q <= '0;
            wd_q        <= '0;
            last_seen_q <= 1'b0;
            error_q     <= 1'b0;
            digest_q    <= '0;
        end else begin
            state_q     <= state_d;
            block_cnt_q <= block_cnt_d;
            wd_q        <= wd_d;
            last_seen_q <= last_seen_d;
            error_q     <= error_d;
            digest_q    <= digest_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        block_cnt_d = block_cnt_q;
        wd_d        = wd_q;
        last_seen_d = last_seen_q;
        error_d     = error_q;
        digest_d    = digest_q;
        w_buf_clr   = 1'b0;
        w_buf_wr    = 1'b0;
        w_rst_hash  = 1'b0;

        if (abort_i) begin
            w_rst_hash = 1'b1;
            state_d    = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        w_rst_hash  = 1'b1;
                        w_buf_clr   = 1'b1;
                        block_cnt_d = '0;
                        error_d     = 1'b0;
                        last_seen_d = 1'b0;
                        state_d     = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (s_valid_i) begin
                        // A premature last word means the host padding is broken.
                        if (s_last_i && !w_last_word) begin
                            error_d    = 1'b1;
                            w_rst_hash = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            w_buf_wr = 1'b1;
                            if (w_last_word) begin
                                last_seen_d = s_last_i;
                                if (block_cnt_q != 16'hFFFF) begin
                                    block_cnt_d = block_cnt_q + 16'd1;
                                end
                                wd_d    = '0;
                                state_d = ST_HASH;
                            end
                        end
                    end
                end
                ST_HASH: begin
                    if (digest_valid_i) begin
                        digest_d = digest_i;
                        state_d  = ST_DONE;
                    end else if (hold_i) begin
                        last_seen_d = 1'b0;
                        state_d     = ST_FILL;
                    end else if (wd_q == WD_W'(TimeoutCycles - 1)) begin
                        error_d    = 1'b1;
                        w_rst_hash = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign s_ready_o     = (state_q == ST_FILL);
    assign enable_hash_o = (state_q == ST_HASH);
    assign busy_o        = (state_q == ST_FILL) || (state_q == ST_HASH);
    assign done_o        = (state_q == ST_DONE);
    assign rst_hash_o    = !rst_ni || w_rst_hash;
    assign error_o       = error_q;
    assign digest_o      = digest_q;
    assign block_cnt_o   = block_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_block_seq.sv
// ============================================================================
// tb_sha256_block_seq : directed + randomized bench with a behavioural
//                       SHA-256 core model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_block_seq;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIGEST = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam int CORE_LAT = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni, start_i, abort_i, s_valid_i, s_ready_o, s_last_i;
    logic [31:0]  s_data_i;
    logic [511:0] block_o;
    logic         enable_hash_o, rst_hash_o, hold_i, idle_i, digest_valid_i;
    logic [255:0] digest_i, digest_o;
    logic         busy_o, done_o, error_o;
    logic [15:0]  block_cnt_o;

    int tests = 0;
    int fails = 0;
    int hold_cnt = 0;
    int widx;
    logic [511:0] mbuf;
    logic [511:0] exp_blk [3];
    bit   core_silent;
    int   core_blocks;

    sha256_block_seq dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .s_data_i       (s_data_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .s_last_i       (s_last_i),
        .block_o        (block_o),
        .enable_hash_o  (enable_hash_o),
        .rst_hash_o     (rst_hash_o),
        .hold_i         (hold_i),
        .idle_i         (idle_i),
        .digest_valid_i (digest_valid_i),
        .digest_i       (digest_i),
        .digest_o       (digest_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .block_cnt_o    (block_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
                 + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    // Behavioural core: hashes block_o some cycles after enable, then asks for
    // another block (hold) or presents the digest after core_blocks blocks.
    logic [255:0] core_h;
    int  core_lat, core_nblk;
    bit  core_wait;
    always @(posedge clk_i) begin
        hold_i         <= 1'b0;
        digest_valid_i <= 1'b0;
        if (rst_hash_o) begin
            core_h <= IV; core_lat <= 0; core_wait <= 1'b0; core_nblk <= 0; idle_i <= 1'b1;
            digest_i <= '0;
        end else if (!enable_hash_o) begin
            core_lat <= 0; core_wait <= 1'b0; idle_i <= 1'b1;
        end else if (core_silent || core_wait) begin
            idle_i <= 1'b0;
        end else begin
            idle_i <= 1'b0;
            if (core_lat == CORE_LAT) begin
                core_wait <= 1'b1;
                core_h    <= sha_compress(core_h, block_o);
                core_nblk <= core_nblk + 1;
                if (core_nblk + 1 < core_blocks) hold_i <= 1'b1;
                else begin
                    digest_valid_i <= 1'b1;
                    digest_i       <= sha_compress(core_h, block_o);
                end
            end else begin
                core_lat <= core_lat + 1;
            end
        end
    end

    always @(posedge clk_i) if (hold_i) hold_cnt <= hold_cnt + 1;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        #1;
        chk("start_rst_hash", rst_hash_o, 1);
        step();
        start_i = 1'b0;
        widx = 0;
        chk("start_busy", {busy_o, s_ready_o, error_o, done_o}, 4'b1100);
        chk("start_blkcnt", block_cnt_o, 0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, input bit rnd);
        bit x;
        int n;
        x = 1'b0;
        n = 0;
        while (!x && n < 200) begin
            s_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data_i  = s_valid_i ? w : $urandom;
            s_last_i  = s_valid_i ? last : 1'($urandom_range(0, 1));
            x = s_valid_i && s_ready_o;
            step();
            n++;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        if (!x) chk("xfer_timeout", 0, 1);
        mbuf[511 - 32*widx -: 32] = w;
        widx = (widx + 1) % 16;
    endtask

    task automatic send_block(input logic [511:0] blk, input bit last, input bit rnd);
        for (int k = 0; k < 16; k++) send_word(blk[511 - 32*k -: 32], last && (k == 15), rnd);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_o && n < 300) begin
            step();
            n++;
        end
        chk(tag, done_o, 1);
    endtask

    initial begin
        logic [511:0] blk;
        logic [255:0] h;
        int h0, n;

        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = '0;
        core_silent = 1'b0; core_blocks = 1; widx = 0; mbuf = '0;
        repeat (3) step();
        chk("rst_hash_in_reset", rst_hash_o, 1);
        chk("rst_flags", {busy_o, done_o, error_o, s_ready_o, enable_hash_o}, 0);
        chk("rst_block", block_o, 0);
        chk("rst_digest", digest_o, 0);
        chk("rst_blkcnt", block_cnt_o, 0);
        rst_ni = 1'b1;
        #1;
        chk("post_rst_hash", rst_hash_o, 0);

        // Words offered while idle must not be consumed.
        s_valid_i = 1'b1; s_data_i = 32'hdeadbeef;
        repeat (3) step();
        chk("idle_ignore", {s_ready_o, busy_o, block_o}, 0);
        s_valid_i = 1'b0;

        // "abc", single block.
        core_blocks = 1;
        do_start();
        blk = '0;
        blk[511:480] = 32'h61626380;
        blk[31:0]    = 32'h00000018;
        send_block(blk, 1'b1, 1'b0);
        chk("abc_enable", enable_hash_o, 1);
        chk("abc_block", block_o, blk);
        wait_done("abc_done");
        chk("abc_digest", digest_o, ABC_DIGEST);
        chk("abc_blkcnt", block_cnt_o, 1);
        repeat (4) step();
        chk("abc_held", {done_o, busy_o, digest_o}, {2'b10, ABC_DIGEST});

        // Two-block message, started from DONE.
        core_blocks = 2;
        h0 = hold_cnt;
        do_start();
        for (int i = 0; i < 14; i++) blk[511 - 32*i -: 32] = {8'h61 + 8'(i), 8'h62 + 8'(i), 8'h63 + 8'(i), 8'h64 + 8'(i)};
        blk[63:32] = 32'h80000000;
        blk[31:0]  = 32'h0;
        send_block(blk, 1'b0, 1'b0);
        chk("two_blk1", block_o, blk);
        blk = '0;
        blk[31:0] = 32'h000001c0;
        send_block(blk, 1'b1, 1'b0);
        chk("two_blk2", block_o, blk);
        chk("two_hold_once", hold_cnt - h0, 1);
        wait_done("two_done");
        chk("two_digest", digest_o, TWO_DIGEST);
        chk("two_blkcnt", block_cnt_o, 2);

        // Random three-block message with 50% valid duty.
        core_blocks = 3;
        do_start();
        h = IV;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) exp_blk[b][511 - 32*i -: 32] = $urandom;
            h = sha_compress(h, exp_blk[b]);
            send_block(exp_blk[b], b == 2, 1'b1);
            chk("rnd_enable", enable_hash_o, 1);
            chk("rnd_block", block_o, exp_blk[b]);
            chk("rnd_blkcnt", block_cnt_o, b + 1);
        end
        wait_done("rnd_done");
        chk("rnd_digest", digest_o, h);

        // Abort during HASH.
        core_silent = 1'b1;
        do_start();
        for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
        send_block(blk, 1'b1, 1'b0);
        repeat (30) step();
        chk("abort_in_hash", enable_hash_o, 1);
        abort_i = 1'b1;
        #1;
        chk("abort_rst_hash", rst_hash_o, 1);
        step();
        abort_i = 1'b0;
        chk("abort_idle", {busy_o, done_o, s_ready_o, enable_hash_o, error_o}, 0);
        chk("abort_digest_kept", digest_o, h);
        n = 0;
        while (!idle_i && n < 2) begin
            step();
            n++;
        end
        chk("abort_core_idle", idle_i, 1);

        // Premature s_last on word 9.
        do_start();
        for (int i = 0; i < 9; i++) send_word($urandom, 1'b0, 1'b0);
        s_valid_i = 1'b1; s_last_i = 1'b1; s_data_i = 32'hbad0bad0;
        #1;
        chk("early_last_rst_hash", rst_hash_o, 1);
        step();
        s_valid_i = 1'b0; s_last_i = 1'b0;
        chk("early_last_err", {error_o, busy_o, s_ready_o}, 3'b100);
        chk("early_last_discard", block_o, mbuf);
        do_start();
        chk("start_clears_err", error_o, 0);

        // Watchdog with a silent core.
        for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
        send_block(blk, 1'b1, 1'b0);
        for (int i = 1; i <= 96; i++) begin
            step();
            if (i == 95) chk("wd_before", {error_o, busy_o, rst_hash_o}, 3'b011);
            if (i == 96) chk("wd_fire", {error_o, busy_o, done_o}, 3'b100);
        end
        core_silent = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
